adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//  Parametrised pipelined ripple-carry adder/subtractor, successor to the 1-bit full-adder cell.
//  Splits a WIDTH-bit add into STAGES chunks, one chunk per registered stage; carry ripples stage-to-stage.
//  valid/ready on both sides, full throughput (1 op/cycle), backpressure with bubble collapse.
//  Sits between operand producers and result consumers in the datapath test harnesses.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES must be 0 (elaboration $error otherwise)
//  STAGES  4   pipeline stages = latency in cycles; 1 <= STAGES <= WIDTH; chunk = WIDTH/STAGES bits
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a, b, carry_in, sub valid this cycle
//  in_ready   out  1      pipeline can accept; transfer when in_valid && in_ready
//  a          in   WIDTH  operand A (two's complement or unsigned)
//  b          in   WIDTH  operand B
//  carry_in   in   1      carry into bit 0 (ignored when sub=1)
//  sub        in   1      0: a+b+carry_in; 1: a-b (a + ~b + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//  c          out  WIDTH  sum/difference
//  carry_out  out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//  overflow   out  1      signed overflow: sign(a)==sign(b_eff) && sign(c)!=sign(a)
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valid bits 0, all data/carry regs 0; outputs c=0, carry_out=0,
//    overflow=0, out_valid=0, in_ready=0 while rst=1; in_ready=1 on first cycle after release.
//  - b_eff = sub ? ~b : b; cin_eff = sub ? 1 : carry_in; captured at input transfer.
//  - Stage k (0..STAGES-1) adds chunk k of a, b_eff with carry from stage k-1 (stage 0: cin_eff),
//    registers chunk result + chunk carry; upper operand chunks and lower result chunks skew-registered
//    alongside so each stage holds exactly one transaction.
//  - Latency: input transfer at edge N -> out_valid=1 after edge N+STAGES-1 (STAGES cycles incl. capture).
//  - Advance rule per stage k: adv[k] = v[k] ? (k==last ? out_ready : !v[k+1] || adv[k+1]) : 1.
//    in_ready = !rst && adv[0]-equivalent for stage 0 (empty or moving). Empty stages fill regardless of
//    downstream stall (bubble collapse). Combinational ready chain only; no comb path in_valid->out_valid.
//  - Stalled stage holds data, carry, valid unchanged. Outputs c/carry_out/overflow stable while
//    out_valid && !out_ready; change only after transfer.
//  - Simultaneous in transfer and out transfer with full pipe: both occur, occupancy unchanged.
//  - overflow computed from last stage: MSB of a, MSB of b_eff, MSB of c; unsigned users ignore it.
//  - Arithmetic mod 2^WIDTH; carry_out is bit WIDTH of full-width sum. No saturation.
//  - rst mid-operation: all in-flight transactions discarded, no partial result presented.
//  - STAGES=1: single registered adder, latency 1, in_ready = !out_valid || out_ready.
// STRUCTURE
//  - Shared package adder_pkg: localparam CHUNK = WIDTH/STAGES helper function, typedef for stage
//    record {valid, carry, sub, a_hi, b_hi, c_lo}; overflow-detect function.
//  - One sub-module: adder_chunk (CHUNK-bit combinational ripple of 1-bit full-adder cells,
//    ports a, b, carry_in, c, carry_out); instantiated STAGES times via generate.
//  - adder_pipe itself: stage registers, valid/ready chain, input b/cin muxing, overflow flag.
// TESTING
//  1. WIDTH=32,STAGES=4: a=0xFFFF_FFFF,b=1,cin=0,sub=0 -> after 4 cycles c=0, carry_out=1, overflow=0.
//  2. sub=1, a=5, b=7 -> c=0xFFFF_FFFE, carry_out=0 (borrow); a=0x8000_0000,b=1 -> c=0x7FFF_FFFF, overflow=1.
//  3. Streaming: 16 back-to-back ops with out_ready=1 -> 16 results on consecutive cycles, in order,
//     matching a+b+cin reference model; in_ready never drops.
//  4. Backpressure: out_ready=0 for 10 cycles while feeding -> exactly STAGES ops accepted, in_ready=0
//     thereafter, c held stable; release -> results drain in order, none lost or duplicated.
//  5. Random in_valid/out_ready (50%) for 10k ops, WIDTH=8/STAGES=2 and WIDTH=16/STAGES=1 -> scoreboard clean.
//  6. Assert rst with 3 ops in flight -> out_valid=0, c=0 immediately (async); after release
//     in_ready=1, no stale result ever appears.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Holds the 1-bit full-adder cell, chunk sizing and the signed-overflow rule.
package adder_pkg;

  // Per-stage control bits; the width-dependent operand/result fields live
  // in a stage record declared inside adder_pipe.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  // Returns {carry, sum} of one full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
    return {co, s};
  endfunction

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic overflow_detect(input logic a_msb, input logic b_msb,
                                           input logic c_msb);
    return (a_msb == b_msb) && (c_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry adder for one pipeline chunk, built from
// full-adder cells; one instance per pipeline stage.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] c,
  output logic             carry_out
);

  logic carry;

  always_comb begin
    // NOTE: blocking assignments are what make the ripple work here: each bit
    // reads the carry the bit below just produced in this same evaluation.
    carry = carry_in;
    c     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {carry, c[i]} = full_add(a[i], b[i], carry);
    end
  end

  assign carry_out = carry;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor: WIDTH bits split into STAGES chunks, one chunk
// added per registered stage, valid/ready handshake with bubble collapse.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("adder_pipe: WIDTH=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  // Each stage carries the full operands and the partially built result;
  // chunks below the stage index of c are final, chunks above are still zero.
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } stage_t;

  stage_t            pipe_q   [STAGES];
  stage_t            stage_in [STAGES];
  stage_t            stage_d  [STAGES];
  logic [CHUNK-1:0]  sum      [STAGES];
  logic              cout     [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic              down_ready;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  // Subtraction is a + ~b + 1; carry_in is ignored in that mode.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | carry_in;

  always_comb begin : input_select
    stage_in[0].ctrl.valid = in_valid;
    stage_in[0].ctrl.carry = cin_eff;
    stage_in[0].a          = a;
    stage_in[0].b          = b_eff;
    stage_in[0].c          = '0;
    for (int k = 1; k < STAGES; k++) begin
      stage_in[k] = pipe_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    adder_chunk #(
      .WIDTH(CHUNK)
    ) u_chunk (
      .a        (stage_in[k].a[k*CHUNK +: CHUNK]),
      .b        (stage_in[k].b[k*CHUNK +: CHUNK]),
      .carry_in (stage_in[k].ctrl.carry),
      .c        (sum[k]),
      .carry_out(cout[k])
    );
  end

  always_comb begin : stage_next
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k]                     = stage_in[k];
      stage_d[k].ctrl.carry          = cout[k];
      stage_d[k].c[k*CHUNK +: CHUNK] = sum[k];
    end
  end

  always_comb begin : valid_vector
    valid = '0;
    for (int k = 0; k < STAGES; k++) begin
      valid[k] = pipe_q[k].ctrl.valid;
    end
  end

  // A stage may take new contents when it is empty or its occupant moves on;
  // the chain runs from the consumer back to the input.
  always_comb begin : ready_chain
    adv        = '0;
    down_ready = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k]     = !valid[k] || down_ready;
      down_ready = adv[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every stage register is cleared on reset, data included, so a
      // discarded transaction can never surface on c after reset releases.
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          pipe_q[k] <= stage_d[k];
        end
      end
    end
  end

  assign in_ready  = !rst && adv[0];
  assign out_valid = pipe_q[LAST].ctrl.valid;
  assign c         = pipe_q[LAST].c;
  assign carry_out = pipe_q[LAST].ctrl.carry;
  assign overflow  = overflow_detect(pipe_q[LAST].a[WIDTH-1], pipe_q[LAST].b[WIDTH-1],
                                     pipe_q[LAST].c[WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: a 32-bit/4-stage instance with a result
// scoreboard, plus a 16-bit/1-stage instance for the single-register case.
module tb_adder_pipe;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, carry_in, sub;
  logic         out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] a, b, c;

  logic          in_valid_s, in_ready_s, carry_in_s, sub_s;
  logic          out_valid_s, out_ready_s, carry_out_s, overflow_s;
  logic [W1-1:0] a_s, b_s, c_s;

  int n_vec    = 0;
  int n_miss   = 0;
  int rx_total = 0;

  typedef struct packed {
    logic [31:0] c;
    logic        co;
    logic        ov;
  } res_t;

  res_t exp_q[$];

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .carry_out(carry_out), .overflow(overflow)
  );

  adder_pipe #(.WIDTH(W1), .STAGES(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s), .in_ready(in_ready_s),
    .a(a_s), .b(b_s), .carry_in(carry_in_s), .sub(sub_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .c(c_s), .carry_out(carry_out_s), .overflow(overflow_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic su);
    res_t        r;
    longint      sx, sy, t;
    logic [32:0] s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (su) begin
      r.c  = x - y;
      r.co = (x >= y);
      t    = sx - sy;
    end else begin
      s    = {1'b0, x} + {1'b0, y} + {32'b0, ci};
      r.c  = s[31:0];
      r.co = s[32];
      t    = sx + sy + (ci ? 64'sd1 : 64'sd0);
    end
    r.ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops on every output transfer, pushes on every input transfer.
  task automatic monitor_loop();
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          rx_total++;
          if (exp_q.size() == 0) begin
            check("sb_spurious", 64'(out_valid), 64'(0));
          end else begin
            r = exp_q.pop_front();
            check("sb_c", 64'(c), 64'(r.c));
            check("sb_carry", 64'(carry_out), 64'(r.co));
            check("sb_ovf", 64'(overflow), 64'(r.ov));
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, carry_in, sub));
      end
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic su,
                          input logic [31:0] ec, input logic eco, input logic eov);
    int lat;
    out_ready = 1'b1;
    a = av; b = bv; carry_in = ci; sub = su; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check({tag, "_latency"}, 64'(lat), 64'(S));
    check({tag, "_c"}, 64'(c), 64'(ec));
    check({tag, "_carry"}, 64'(carry_out), 64'(eco));
    check({tag, "_ovf"}, 64'(overflow), 64'(eov));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   outs, first, last, drops, acc, late_ready, base, lat, stale;
    logic captured;
    logic [31:0] held;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    in_valid_s = 1'b0; out_ready_s = 1'b0; a_s = '0; b_s = '0; carry_in_s = 1'b0; sub_s = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset state
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_c", 64'(c), 64'(0));
    check("rst_carry", 64'(carry_out), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(1));
    check("rel_in_ready_s", 64'(in_ready_s), 64'(1));
    step();

    // Hand-computed single operations
    directed("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("borrow",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("cin_ovf",  32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("chunk_cy", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    directed("sub_cin",  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    directed("neg_ovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Streaming: 16 back-to-back ops with the consumer always ready
    out_ready = 1'b1;
    outs = 0; first = -1; last = -1; drops = 0;
    for (int i = 0; i < 16 + S + 2; i++) begin
      if (i < 16) begin
        a        = 32'(32'h9E37_79B9 * (i + 1));
        b        = {a[15:0], a[31:16]} ^ 32'(32'h1111_1111 * i);
        carry_in = i[0];
        sub      = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 16 && !in_ready) drops++;
      if (out_valid) begin
        outs++;
        if (first < 0) first = i;
        last = i;
      end
      step();
    end
    check("stream_count", 64'(outs), 64'(16));
    check("stream_span", 64'(last - first), 64'(15));
    check("stream_ready_drops", 64'(drops), 64'(0));

    // Backpressure: consumer stalled for 10 cycles while the producer pushes
    out_ready = 1'b0;
    acc = 0; late_ready = 0; captured = 1'b0; held = '0;
    for (int i = 0; i < 10; i++) begin
      a        = 32'(32'h0101_0101 * (acc + 1));
      b        = 32'h00FF_00FF;
      carry_in = 1'b1;
      sub      = acc[0];
      in_valid = 1'b1;
      #1;
      if (acc >= S && in_ready) late_ready++;
      if (in_ready) acc++;
      if (out_valid && !captured) begin
        held     = c;
        captured = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    check("bp_accepted", 64'(acc), 64'(S));
    check("bp_late_ready", 64'(late_ready), 64'(0));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_c_first", 64'(c), 64'(32'h0200_0201));
    check("bp_c_held", 64'(c), 64'(held));
    base = rx_total;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("bp_drained", 64'(rx_total - base), 64'(S));
    check("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reset with three transactions in flight and one presented
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'hFFFF_FFFF - 32'(i); b = 32'hFFFF_FFFF; carry_in = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_out(lat);
    check("mid_pre_valid", 64'(out_valid), 64'(1));
    check("mid_pre_c", 64'(c), 64'(32'hFFFF_FFFE));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_c", 64'(c), 64'(0));
    check("mid_rst_carry", 64'(carry_out), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    step();
    step();
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) stale++;
    end
    check("mid_no_stale", 64'(stale), 64'(0));

    // Single-stage instance: latency 1, in_ready = !out_valid || out_ready
    a_s = 16'h7FFF; b_s = 16'h0001; carry_in_s = 1'b0; sub_s = 1'b0;
    out_ready_s = 1'b0; in_valid_s = 1'b1;
    step();
    in_valid_s = 1'b0;
    #1;
    check("s1_out_valid", 64'(out_valid_s), 64'(1));
    check("s1_c", 64'(c_s), 64'(16'h8000));
    check("s1_carry", 64'(carry_out_s), 64'(0));
    check("s1_ovf", 64'(overflow_s), 64'(1));
    check("s1_stall_ready", 64'(in_ready_s), 64'(0));
    step();
    check("s1_held_c", 64'(c_s), 64'(16'h8000));
    out_ready_s = 1'b1;
    a_s = 16'h0003; b_s = 16'h0003; sub_s = 1'b1; in_valid_s = 1'b1;
    #1;
    check("s1_pass_ready", 64'(in_ready_s), 64'(1));
    step();
    in_valid_s = 1'b0;
    check("s1_sub_valid", 64'(out_valid_s), 64'(1));
    check("s1_sub_c", 64'(c_s), 64'(16'h0000));
    check("s1_sub_carry", 64'(carry_out_s), 64'(1));
    check("s1_sub_ovf", 64'(overflow_s), 64'(0));
    step();
    check("s1_empty", 64'(out_valid_s), 64'(0));

    check("sb_final_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
